// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, prefetch FIFO, redirect and halt control.
// Define FETCH_BYPASS_EN to forward imem_rdata straight to the consumer when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        FULL,
        HALTED
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc;
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count, count_nx;
    logic          fifo_empty, fifo_full;
    logic          pop, push, advance, bypass, bypass_take;
    logic          unused_redirect_lsb;

    assign imem_addr           = {fetch_pc[31:2], 2'b00};
    assign halted              = (state == HALTED);
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);

        bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
        // rst gate keeps the outputs quiet while reset is held
        bypass = fifo_empty && (state == RUN) && !redirect_valid && !rst;
`endif
        bypass_take = bypass && instr_ready;

        // redirect suppresses both ends of the FIFO for this cycle
        pop     = !fifo_empty && instr_ready && !redirect_valid;
        advance = !redirect_valid && (state != HALTED) && (!fifo_full || pop);
        push    = advance && !bypass_take;

        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase

        if (bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = fetch_pc;
        end else begin
            instr_valid = !fifo_empty;
            instr       = fifo_empty ? '0 : mem[rptr][31:0];
            instr_pc    = fifo_empty ? '0 : mem[rptr][63:32];
        end

        if (redirect_valid)
            state_nx = halt_req ? HALTED : RUN;
        else if (halt_req)
            state_nx = HALTED;
        else if (state == HALTED)
            state_nx = RUN;
        else if ((count_nx == FULL_CNT) && !pop)
            state_nx = FULL;
        else
            state_nx = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rptr     <= '0;
                wptr     <= '0;
                count    <= '0;
            end else begin
                if (advance)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push)
                    wptr <= wptr + PW'(1);
                if (pop)
                    rptr <= rptr + PW'(1);
                count <= count_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {fetch_pc, imem_rdata};
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch FIFO entry count (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address to instruction memory.
REQ-006 SHALL have port imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-007 SHALL have port instr  output  32  instruction at the FIFO head.
REQ-008 SHALL have port instr_pc  output  32  PC of instr.
REQ-009 SHALL have port instr_valid  output  1  instr/instr_pc are valid.
REQ-010 SHALL have port instr_ready  input  1  consumer accepts; transfer when instr_valid && instr_ready.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-012 SHALL have port redirect_pc  input  32  redirect target.
REQ-013 SHALL have port halt_req  input  1  level request to stop fetching.
REQ-014 SHALL have port halted  output  1  high while in state HALTED.

Function
REQ-015 SHALL hold fetch_pc and drive imem_addr = {fetch_pc[31:2], 2'b00} continuously.
REQ-016 SHALL implement states RUN, FULL, HALTED; RUN->FULL when the FIFO becomes full with no pop; FULL->RUN on pop; any->HALTED when halt_req=1 and no redirect; HALTED->RUN when halt_req=0.
REQ-017 SHALL, in RUN (or FULL with a same-cycle pop), push {fetch_pc, imem_rdata} and advance fetch_pc by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-018 SHALL NOT push or advance fetch_pc in HALTED or in FULL without a pop.
REQ-019 SHALL present the FIFO head on instr/instr_pc with instr_valid = FIFO not empty; outputs SHALL be stable while instr_valid && !instr_ready.
REQ-020 SHALL, on redirect_valid, flush all FIFO entries, set fetch_pc <= {redirect_pc[31:2],2'b00}, suppress that cycle's push and pop, and enter RUN unless halt_req=1 (then HALTED).
REQ-021 SHALL give redirect priority over halt, pop and push in the same cycle.
REQ-022 SHALL allow simultaneous push and pop when full (occupancy unchanged) and when empty only via bypass (REQ-030).
REQ-023 SHALL keep FIFO occupancy in a counter 0..DEPTH with wrap-around read/write pointers.
REQ-024 SHALL, without bypass, deliver the first instruction after reset or redirect one cycle after its fetch (instr_valid in cycle N+1).
REQ-025 SHALL drain remaining FIFO entries to the consumer while HALTED.

Reset
REQ-026 SHALL on rst=1 immediately set fetch_pc=RESET_PC, FIFO empty, pointers and count 0, state RUN.
REQ-027 SHALL drive during reset: instr_valid=0, halted=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
REQ-028 SHALL discard all in-flight entries on reset asserted mid-operation; first fetch after release is RESET_PC.

Configuration
REQ-029 SHALL use macro FETCH_BYPASS_EN.
REQ-030 SHALL, when FETCH_BYPASS_EN is defined, with FIFO empty in RUN and no redirect, drive instr=imem_rdata, instr_pc=fetch_pc, instr_valid=1 combinationally; if instr_ready=1 the word is consumed without a push and fetch_pc advances; if 0 it is pushed normally.
REQ-031 SHALL, when FETCH_BYPASS_EN is undefined, have no combinational path from imem_rdata to instr/instr_valid.

Verification
REQ-032 Reset release, instr_ready=1, mem[i]=i+1 -> instr_pc 0,4,8,12 on consecutive cycles with instr 1,2,3,4; first valid cycle 1 after release (cycle 0 with FETCH_BYPASS_EN).
REQ-033 instr_ready=0 for 10 cycles, DEPTH=4 -> FULL after 4 pushes, imem_addr held at 16, instr_pc held 0; ready=1 -> 0,4,8,12,16 in order, no loss/duplicates.
REQ-034 redirect_valid with redirect_pc=32'h2E while 3 entries queued -> next cycle instr_valid=0 (no bypass), imem_addr=32'h2C; next delivered instr_pc=32'h2C.
REQ-035 redirect_valid and halt_req same cycle -> FIFO flushed, fetch_pc=target, halted=1; halt_req=0 -> fetch resumes at target.
REQ-036 RESET_PC=32'hFFFF_FFF8, ready=1 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst asserted asynchronously mid-burst with 2 entries queued -> instr_valid=0 immediately; after release first instr_pc=RESET_PC.
